fifo_pkt_drain: RTL and testbench

FIFO_PKT_DRAIN -- requirements
Module: fifo_pkt_drain

---
 rtl/fifo_pkt_drain_pkg.sv | 21 ++
 rtl/fifo_pkt_drain_if.sv | 23 ++
 rtl/fifo_pkt_drain_timeout.sv | 33 +++
 rtl/fifo_pkt_drain.sv | 139 +++++++++++++
 tb/tb_fifo_pkt_drain.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkt_drain_pkg.sv
// Shared constants for the FIFO read-side packet drain: FIFO widths, default
// framing words and the drain FSM state encoding.
package fifo_pkt_drain_pkg;

    localparam int FIFO_DATA_W = 8;
    // Wide enough for the 1..255 ranges of PKT_LEN and TIMEOUT
    localparam int CNT_W       = 8;

    localparam logic [7:0] DEFAULT_HDR = 8'hA5;
    localparam logic [7:0] DEFAULT_PAD = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_READ     = 3'd2,
        ST_LOAD     = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_CHECKSUM = 3'd5
    } drain_state_t;

endpackage

// File: rtl/fifo_pkt_drain_if.sv
// Upstream FIFO read port plus downstream valid/ready stream, bundled so the
// drain sees one master-side view and the environment the slave-side view.
interface fifo_pkt_drain_if #(
    parameter int N = fifo_pkt_drain_pkg::FIFO_DATA_W
) ();
    logic         fifo_empty;
    logic [N-1:0] fifo_data;
    logic         fifo_rd_en;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fifo_pkt_drain_timeout.sv
// Consecutive-empty-cycle counter: counts while i_count is high and pulses
// o_expire on the TIMEOUT-th counted cycle, restarting from zero.
module drain_timeout
    import fifo_pkt_drain_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_out,
    input  logic arst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    logic [CNT_W-1:0] r_count;
    logic             w_hit;

    assign w_hit    = (r_count == CNT_W'(TIMEOUT - 1));
    assign o_expire = i_count && w_hit;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_out or posedge arst) begin
        if (arst) begin
            r_count <= '0;
        end else if (i_clear || o_expire) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_pkt_drain.sv
// Drains PKT_LEN words from an upstream FIFO into a framed stream:
// header, payload (PAD-substituted on timeout), then a mod-2^N checksum.
module fifo_pkt_drain
    import fifo_pkt_drain_pkg::*;
#(
    parameter int           N       = FIFO_DATA_W,
    parameter int           PKT_LEN = 4,
    parameter logic [N-1:0] HDR     = N'(DEFAULT_HDR),
    parameter logic [N-1:0] PAD     = N'(DEFAULT_PAD),
    parameter int           TIMEOUT = 16
) (
    input  logic                clk_out,
    input  logic                arst,
    fifo_pkt_drain_if.master    bus,
    output logic                busy,
    output logic                underrun,
    output logic [15:0]         pkt_count
);

    drain_state_t     r_state;
    drain_state_t     w_next_state;

    logic [N-1:0]     r_hold;
    logic [N-1:0]     r_sum;
    logic [CNT_W-1:0] r_word_cnt;
    logic [15:0]      r_pkt_count;

    logic             w_hs;
    logic             w_last_word;
    logic             w_to_clear;
    logic             w_to_count;
    logic             w_expire;

    assign w_hs        = bus.m_valid && bus.m_ready;
    assign w_last_word = (r_word_cnt == CNT_W'(PKT_LEN - 1));
    assign w_to_count  = (r_state == ST_READ) && bus.fifo_empty;
    assign w_to_clear  = ((r_state == ST_HEADER) && w_hs) ||
                         ((r_state == ST_READ) && !bus.fifo_empty);

    assign busy      = (r_state != ST_IDLE);
    assign pkt_count = r_pkt_count;

    drain_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_out  (clk_out),
        .arst     (arst),
        .i_clear  (w_to_clear),
        .i_count  (w_to_count),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_out or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (!bus.fifo_empty) w_next_state = ST_HEADER;
            ST_HEADER:   if (w_hs) w_next_state = ST_READ;
            ST_READ: begin
                if (!bus.fifo_empty) begin
                    w_next_state = ST_LOAD;
                end else if (w_expire) begin
                    w_next_state = ST_PAYLOAD;
                end
            end
            ST_LOAD:     w_next_state = ST_PAYLOAD;
            ST_PAYLOAD:  if (w_hs) w_next_state = w_last_word ? ST_CHECKSUM : ST_READ;
            ST_CHECKSUM: if (w_hs) w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decode from state alone, so they hold steady through a stall
    always_comb begin
        bus.fifo_rd_en = 1'b0;
        bus.m_valid    = 1'b0;
        bus.m_data     = '0;
        bus.m_last     = 1'b0;
        underrun       = 1'b0;
        case (r_state)
            ST_HEADER: begin
                bus.m_valid = 1'b1;
                bus.m_data  = HDR;
            end
            ST_READ: begin
                bus.fifo_rd_en = !bus.fifo_empty;
                underrun       = w_expire;
            end
            ST_PAYLOAD: begin
                bus.m_valid = 1'b1;
                bus.m_data  = r_hold;
            end
            ST_CHECKSUM: begin
                bus.m_valid = 1'b1;
                bus.m_data  = r_sum;
                bus.m_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_out or posedge arst) begin
        if (arst) begin
            r_hold      <= '0;
            r_sum       <= '0;
            r_word_cnt  <= '0;
            r_pkt_count <= '0;
        end else begin
            case (r_state)
                ST_HEADER: begin
                    if (w_hs) begin
                        r_sum      <= '0;
                        r_word_cnt <= '0;
                    end
                end
                ST_READ:     if (w_expire) r_hold <= PAD;
                ST_LOAD:     r_hold <= bus.fifo_data;
                ST_PAYLOAD: begin
                    if (w_hs) begin
                        r_sum      <= r_sum + r_hold;
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                    end
                end
                ST_CHECKSUM: if (w_hs) r_pkt_count <= r_pkt_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_drain.sv
// Directed bench for fifo_pkt_drain: table of 4-word packets with expected
// streams, plus underrun, mid-packet reset and pkt_count wrap sequences.
module tb_fifo_pkt_drain;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic [7:0] din [4];
        bit         toggle;
        logic [7:0] exp_sum;
    } vec_t;

    logic        clk_out = 1'b0;
    logic        arst    = 1'b1;
    logic        busy;
    logic        underrun;
    logic [15:0] pkt_count;

    fifo_pkt_drain_if #(.N(8)) bus ();

    fifo_pkt_drain #(
        .N       (8),
        .PKT_LEN (4),
        .HDR     (8'hA5),
        .PAD     (8'h00),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_out   (clk_out),
        .arst      (arst),
        .bus       (bus),
        .busy      (busy),
        .underrun  (underrun),
        .pkt_count (pkt_count)
    );

    always #5 clk_out = ~clk_out;

    // Upstream FIFO model: data appears the cycle after the read strobe
    logic [7:0] mem [128];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    initial bus.fifo_data = 8'h00;
    always @(posedge clk_out) begin
        if (!arst && bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            bus.fifo_data <= mem[rd_ptr % 128];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    int         cyc = 0;
    logic [7:0] col_data [16];
    bit         col_last [16];
    int         n_col = 0;
    bit         done = 1'b0;
    int         busy_cycles = 0;
    int         stall_cycles = 0;
    int         n_under = 0;
    int         under_cyc [4];
    int         rd_viol = 0;
    int         stall_viol = 0;
    int         idle_data_viol = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    bit         prev_last;

    always @(posedge clk_out) cyc <= cyc + 1;

    // Outputs sampled on the falling edge, between input updates and active edges
    always @(negedge clk_out) begin
        if (arst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_rd_en && bus.fifo_empty) rd_viol++;
            if (!bus.m_valid && bus.m_data != 8'h00) idle_data_viol++;
            if (busy) busy_cycles++;
            if (underrun) begin
                if (n_under < 4) under_cyc[n_under] = cyc;
                n_under++;
            end
            if (prev_stall) begin
                stall_cycles++;
                if (!(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last))
                    stall_viol++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if (bus.m_valid && bus.m_ready) begin
                if (n_col < 16) begin
                    col_data[n_col] = bus.m_data;
                    col_last[n_col] = bus.m_last;
                end
                n_col++;
                if (bus.m_last) done = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 128] = d;
        wr_ptr++;
    endtask

    function automatic vec_t mk(input logic [31:0] words, input bit tog, input logic [7:0] s);
        vec_t v;
        v.din[0]  = words[31:24];
        v.din[1]  = words[23:16];
        v.din[2]  = words[15:8];
        v.din[3]  = words[7:0];
        v.toggle  = tog;
        v.exp_sum = s;
        return v;
    endfunction

    task automatic run_pkt(input logic [7:0] w [4], input int nw, input bit tog, input string tag);
        bit got;
        n_col        = 0;
        done         = 1'b0;
        busy_cycles  = 0;
        stall_cycles = 0;
        n_under      = 0;
        for (int i = 0; i < nw; i++) push(w[i]);
        bus.m_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_out);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (tog) bus.m_ready = !bus.m_ready;
        end
        bus.m_ready = 1'b1;
        check({tag, "_done"}, 32'(got), 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp [6]);
        logic [5:0] lm;
        check({tag, "_words"}, n_col, 6);
        lm = '0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_w%0d", tag, i), col_data[i], exp[i]);
            lm[i] = col_last[i];
        end
        check({tag, "_last_mask"}, 32'(lm), 32'h20);
    endtask

    vec_t       vecs [5];
    logic [7:0] exp_s [6];
    logic [7:0] words [4];
    int         exp_pkts;
    bit         found;

    initial begin
        // Hand-computed checksums (payload only, mod 256)
        vecs[0] = mk(32'h01020304, 1'b0, 8'h0A);
        vecs[1] = mk(32'h01020304, 1'b1, 8'h0A);
        vecs[2] = mk(32'hFFFFFFFF, 1'b0, 8'hFC);
        vecs[3] = mk(32'h10203040, 1'b1, 8'hA0);
        vecs[4] = mk(32'h8080_7F01, 1'b0, 8'h80);

        bus.m_ready = 1'b0;
        #2;
        check("rst_m_valid",  32'(bus.m_valid),    32'd0);
        check("rst_m_data",   32'(bus.m_data),     32'd0);
        check("rst_m_last",   32'(bus.m_last),     32'd0);
        check("rst_rd_en",    32'(bus.fifo_rd_en), 32'd0);
        check("rst_busy",     32'(busy),           32'd0);
        check("rst_underrun", 32'(underrun),       32'd0);
        check("rst_pkt_cnt",  32'(pkt_count),      32'd0);

        repeat (2) @(posedge clk_out);
        #1 arst = 1'b0;

        // Ready without valid and an empty FIFO must leave the block idle
        bus.m_ready = 1'b1;
        repeat (5) @(posedge clk_out);
        #1;
        check("idle_busy",  32'(busy),        32'd0);
        check("idle_valid", 32'(bus.m_valid), 32'd0);
        check("idle_words", n_col,            0);

        exp_pkts = 0;
        for (int v = 0; v < 5; v++) begin
            run_pkt(vecs[v].din, 4, vecs[v].toggle, $sformatf("vec%0d", v));
            exp_pkts++;
            exp_s[0] = 8'hA5;
            for (int i = 0; i < 4; i++) exp_s[i+1] = vecs[v].din[i];
            exp_s[5] = vecs[v].exp_sum;
            check_stream($sformatf("vec%0d", v), exp_s);
            check($sformatf("vec%0d_pkt_cnt", v), 32'(pkt_count), 32'(exp_pkts));
            if (vecs[v].toggle)
                check($sformatf("vec%0d_stalled", v), 32'(stall_cycles > 0), 32'd1);
            else
                check($sformatf("vec%0d_duration", v), busy_cycles, 4 * 3 + 2);
        end

        // Only two words ever arrive: two PAD substitutions follow
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h00; words[3] = 8'h00;
        run_pkt(words, 2, 1'b0, "under");
        exp_pkts++;
        exp_s[0] = 8'hA5; exp_s[1] = 8'h01; exp_s[2] = 8'h02;
        exp_s[3] = 8'h00; exp_s[4] = 8'h00; exp_s[5] = 8'h03;
        check_stream("under", exp_s);
        check("under_pulses", n_under, 2);
        // TIMEOUT empty READ cycles plus the PAD word's PAYLOAD cycle in between
        check("under_spacing", under_cyc[1] - under_cyc[0], TIMEOUT + 1);
        check("under_pkt_cnt", 32'(pkt_count), 32'(exp_pkts));

        // Reset in the middle of a packet, while the first payload word is offered
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        bus.m_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_out);
            if (bus.m_valid && !bus.m_last && bus.m_data == 8'h05) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_found_payload", 32'(found), 32'd1);
        check("mid_pkt_cnt_pre", 32'(pkt_count), 32'(exp_pkts));
        #1 arst = 1'b1;
        #1;
        check("mid_m_valid", 32'(bus.m_valid),    32'd0);
        check("mid_m_data",  32'(bus.m_data),     32'd0);
        check("mid_m_last",  32'(bus.m_last),     32'd0);
        check("mid_rd_en",   32'(bus.fifo_rd_en), 32'd0);
        check("mid_busy",    32'(busy),           32'd0);
        check("mid_pkt_cnt", 32'(pkt_count),      32'd0);
        repeat (2) @(posedge clk_out);
        #1;
        wr_ptr = rd_ptr;
        arst   = 1'b0;
        words[0] = 8'h09; words[1] = 8'h0A; words[2] = 8'h0B; words[3] = 8'h0C;
        run_pkt(words, 4, 1'b0, "post");
        exp_s[0] = 8'hA5; exp_s[1] = 8'h09; exp_s[2] = 8'h0A;
        exp_s[3] = 8'h0B; exp_s[4] = 8'h0C; exp_s[5] = 8'h2A;
        check_stream("post", exp_s);
        check("post_pkt_cnt", 32'(pkt_count), 32'd1);

        // Preset the packet counter at its top value and complete one packet
        force dut.r_pkt_count = 16'hFFFF;
        #1;
        release dut.r_pkt_count;
        #1;
        check("wrap_preset", 32'(pkt_count), 32'h0000FFFF);
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        run_pkt(words, 4, 1'b0, "wrap");
        check("wrap_pkt_cnt", 32'(pkt_count), 32'd0);

        check("rd_en_while_empty", rd_viol,        0);
        check("stall_stability",   stall_viol,     0);
        check("idle_data_zero",    idle_data_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
